// File: rtl/board_pkg.sv
// Shared types and constants for the board run controller: FSM state encoding,
// switch bit positions and the LED byte selector.
package board_pkg;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_HALT    = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_WAITREL = 3'd4
  } state_e;

  localparam int NUM_SW  = 4;
  localparam int SW_RUN  = 0;
  localparam int SW_STEP = 1;
  localparam int SW_SRST = 2;
  localparam int SW_PAGE = 3;

  function automatic logic [7:0] led_byte(input logic page, input logic [15:0] word);
    return page ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One slide switch: 2-FF synchronizer followed by a stable-count debouncer.
// The output follows the synced input once it has differed for DEB_CYCLES cycles.
module sw_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic deb_o
);

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d;
  logic [19:0] cnt_q, cnt_d;

  // Counter never exceeds DEB_CYCLES-1: it is cleared on acceptance or on any bounce back.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_CYCLES - 20'd1) deb_d = sync2_q;
      else                             cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/board_run_ctrl.sv
// Board run controller: debounced switches sequence the core through reset,
// halt, free-run and single-step via a one-cycle clock-enable pulse.
module board_run_ctrl
  import board_pkg::*;
#(
  parameter logic [19:0]          DEB_CYCLES = 20'd500000,
  parameter int                   DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_MAX    = 24'd4999999,
  parameter logic [7:0]           RST_CYCLES = 8'd16
) (
  input  logic        clkOld,
  input  logic        reset_n,
  input  logic [3:0]  switch,
  input  logic [15:0] dbg_word,
  output logic        cpu_en,
  output logic        cpu_rst_n,
  output logic [7:0]  led
);

  logic [NUM_SW-1:0]    deb_sw;
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           rstc_q, rstc_d;
  logic                 en_q, en_d;
  logic [7:0]           led_q, led_d;
  logic                 step_prev_q;
  logic                 step_rise;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i  (clkOld),
      .rst_ni (reset_n),
      .raw_i  (switch[i]),
      .deb_o  (deb_sw[i])
    );
  end

  assign step_rise = deb_sw[SW_STEP] & ~step_prev_q;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    div_d   = '0;
    rstc_d  = '0;
    if (deb_sw[SW_SRST]) begin
      // Held in reset with the count parked at zero until the switch is released.
      state_d = S_RESET;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (rstc_q == RST_CYCLES - 8'd1) state_d = S_HALT;
          else                             rstc_d  = rstc_q + 8'd1;
        end
        S_HALT: begin
          if (deb_sw[SW_RUN]) begin
            state_d = S_RUN;
          end else if (step_rise) begin
            state_d = S_STEP;
            en_d    = 1'b1;
          end
        end
        S_RUN: begin
          if (!deb_sw[SW_RUN]) begin
            state_d = S_HALT;
          end else if (div_q == DIV_MAX) begin
            en_d = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_STEP:    state_d = S_WAITREL;
        S_WAITREL: if (!deb_sw[SW_STEP]) state_d = S_HALT;
        default:   state_d = S_RESET;
      endcase
    end
    led_d = (state_d == S_RESET) ? 8'hFF : led_byte(deb_sw[SW_PAGE], dbg_word);
  end

  always_ff @(posedge clkOld or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET;
      div_q       <= '0;
      rstc_q      <= '0;
      en_q        <= 1'b0;
      led_q       <= 8'h00;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      rstc_q      <= rstc_d;
      en_q        <= en_d;
      led_q       <= led_d;
      step_prev_q <= deb_sw[SW_STEP];
    end
  end

  assign cpu_en    = en_q;
  assign cpu_rst_n = (state_q != S_RESET);
  assign led       = led_q;

endmodule
